load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_lane_align.sv | 40 ++++
 rtl/load_store_unit.sv | 148 ++++++++++++++
 tb/tb_load_store_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states,
// default memory depth and the alignment/legality helper.
package lsu_pkg;

    localparam int DEFAULT_MEM_WORDS = 64;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_e;

    // True when the size encoding is reserved or the offset is not naturally aligned
    function automatic logic is_bad_access(input size_e size, input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = (offset != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extracts and extends load data from a memory
// word, and merges right-aligned store data into the addressed lane(s).
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  size_e       size,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Select the addressed lane, extend it for loads and splice it in for stores
    always_comb begin
        byte_val   = word[{offset, 3'b000} +: 8];
        half_val   = word[{offset[1], 4'b0000} +: 16];
        load_data  = word;
        store_data = word;
        case (size)
            SIZE_BYTE: begin
                load_data = {{24{is_signed & byte_val[7]}}, byte_val};
                store_data[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_HALF: begin
                load_data = {{16{is_signed & half_val[15]}}, half_val};
                store_data[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data  = word;
                store_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, sequences a registered
// single-port memory over a shared tri-state bus, performs read-modify-write
// for sub-word stores and returns a one-cycle response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = DEFAULT_MEM_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_write,
    output logic        mem_out,
    output logic [31:0] mem_address,
    inout  wire  [31:0] mem_data
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

    state_e      state_q, state_d;
    logic        write_q, write_d;
    size_e       size_q, size_d;
    logic        signed_q, signed_d;
    logic [1:0]  offset_q, offset_d;
    logic [31:0] data_q, data_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic        mem_out_q, mem_out_d;
    logic        mem_write_q, mem_write_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic        accept;
    logic        req_bad;
    logic [31:0] load_data;
    logic [31:0] store_data;

    assign req_ready   = (state_q == ST_IDLE) && rst_n;
    assign accept      = req_valid && req_ready;
    assign req_bad     = is_bad_access(size_e'(req_size), req_addr[1:0]) ||
                         (req_addr >= ADDR_LIMIT);

    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign mem_write   = mem_write_q;
    assign mem_out     = mem_out_q;
    assign mem_address = mem_address_q;
    assign mem_data    = mem_write_q ? data_q : 32'bz;

    lsu_lane_align u_align (
        .word       (mem_data),
        .offset     (offset_q),
        .size       (size_q),
        .is_signed  (signed_q),
        .wdata      (data_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    // Next-state sequencing, request latching and registered output values
    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        size_d        = size_q;
        signed_d      = signed_q;
        offset_d      = offset_q;
        data_d        = data_q;
        mem_address_d = mem_address_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    write_d       = req_write;
                    size_d        = size_e'(req_size);
                    signed_d      = req_signed;
                    offset_d      = req_addr[1:0];
                    data_d        = req_wdata;
                    mem_address_d = {req_addr[31:2], 2'b00};
                    if (req_bad) begin
                        state_d = ST_RESP;
                    end else if (req_write && (size_e'(req_size) == SIZE_WORD)) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: state_d = ST_READ;
            ST_READ: begin
                if (write_q) begin
                    data_d  = store_data;
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        mem_out_d   = (state_d == ST_READ);
        mem_write_d = (state_d == ST_WRITE);
        rsp_valid_d = (state_d == ST_RESP);
        rsp_err_d   = accept && req_bad;
        rsp_rdata_d = ((state_q == ST_READ) && !write_q) ? load_data : 32'h0;
    end

    // State and registered outputs, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            write_q       <= 1'b0;
            size_q        <= SIZE_BYTE;
            signed_q      <= 1'b0;
            offset_q      <= 2'b00;
            data_q        <= 32'h0;
            mem_address_q <= 32'h0;
            mem_out_q     <= 1'b0;
            mem_write_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_rdata_q   <= 32'h0;
        end else begin
            state_q       <= state_d;
            write_q       <= write_d;
            size_q        <= size_d;
            signed_q      <= signed_d;
            offset_q      <= offset_d;
            data_q        <= data_d;
            mem_address_q <= mem_address_d;
            mem_out_q     <= mem_out_d;
            mem_write_q   <= mem_write_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered single-port memory model.
module tb_load_store_unit;

    localparam int MEM_WORDS = 64;
    localparam int NV = 24;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_write;
    logic        mem_out;
    logic [31:0] mem_address;
    wire  [31:0] mem_data;

    logic [31:0] mem [MEM_WORDS];
    logic [31:0] rd_buf = 32'h0;
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_val = 32'h0;
    int          mo_cnt = 0;
    int          mw_cnt = 0;
    int          rv_cnt = 0;
    int          overlap_cnt = 0;

    int tests = 0;
    int failed = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        logic        chk_mem;
        logic [5:0]  mem_idx;
        logic [31:0] mem_exp;
    } vec_t;

    vec_t vecs [NV];

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .mem_write   (mem_write),
        .mem_out     (mem_out),
        .mem_address (mem_address),
        .mem_data    (mem_data)
    );

    always #5 clk = ~clk;

    assign mem_data = mem_out ? rd_buf : 32'bz;

    // Memory: output buffer loaded every edge, write on strobe, plus bench preload and strobe counters
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end else if (mem_write) begin
            mem[mem_address[7:2]] <= mem_data;
        end
        rd_buf <= mem[mem_address[7:2]];
        if (mem_out) mo_cnt <= mo_cnt + 1;
        if (mem_write) mw_cnt <= mw_cnt + 1;
        if (rsp_valid) rv_cnt <= rv_cnt + 1;
        if (mem_out && mem_write) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic preloadWord(input logic [5:0] idx, input logic [31:0] val);
        pl_idx = idx;
        pl_val = val;
        pl_en  = 1'b1;
        @(posedge clk);
        #1;
        pl_en  = 1'b0;
    endtask

    // Issue one request (called #1 after an edge), measure latency and check response and strobes
    task automatic applyStimulus(input vec_t v, input int num);
        int lat;
        int mo0, mw0;
        int exp_mo, exp_mw;
        logic got_err;
        logic [31:0] got_rdata;
        bit ready_seen;
        string tag;
        tag = $sformatf("v%0d", num);
        ready_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                ready_seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ready_seen) begin
            checkOutput({tag, "_ready_timeout"}, 32'h0, 32'h1);
            return;
        end
        mo0 = mo_cnt;
        mw0 = mw_cnt;
        req_valid  = 1'b1;
        req_write  = v.wr;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_write  = ~v.wr;
        req_size   = ~v.size;
        req_signed = ~v.sgn;
        req_addr   = ~v.addr;
        req_wdata  = ~v.wdata;
        lat = 0;
        got_err = 1'b0;
        got_rdata = 32'h0;
        for (int n = 1; n <= 8; n++) begin
            if (rsp_valid) begin
                lat = n;
                got_err = rsp_err;
                got_rdata = rsp_rdata;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        checkOutput({tag, "_err"}, {31'h0, got_err}, {31'h0, v.exp_err});
        checkOutput({tag, "_rdata"}, got_rdata, v.exp_rdata);
        @(posedge clk);
        #1;
        checkOutput({tag, "_pulse_width"}, {31'h0, rsp_valid}, 32'h0);
        checkOutput({tag, "_ready_after"}, {31'h0, req_ready}, 32'h1);
        case (v.exp_lat)
            2:       begin exp_mo = 0; exp_mw = 1; end
            3:       begin exp_mo = 1; exp_mw = 0; end
            4:       begin exp_mo = 1; exp_mw = 1; end
            default: begin exp_mo = 0; exp_mw = 0; end
        endcase
        checkOutput({tag, "_mem_out_pulses"}, 32'(mo_cnt - mo0), 32'(exp_mo));
        checkOutput({tag, "_mem_write_pulses"}, 32'(mw_cnt - mw0), 32'(exp_mw));
        if (v.chk_mem) begin
            checkOutput({tag, "_mem_word"}, mem[v.mem_idx], v.mem_exp);
        end
    endtask

    initial begin
        int rv0, mw0;
        vec_t rv;
        //          wr  sz     sg  addr           wdata          err  rdata          lat chk idx    mem
        vecs[0]  = '{0, 2'b00, 1, 32'h0000_0002, 32'h0,         0, 32'hFFFF_FF99, 3, 0, 6'd0,  32'h0};
        vecs[1]  = '{0, 2'b01, 0, 32'h0000_0002, 32'h0,         0, 32'h0000_8899, 3, 0, 6'd0,  32'h0};
        vecs[2]  = '{0, 2'b01, 0, 32'h0000_0001, 32'h0,         1, 32'h0,         1, 0, 6'd0,  32'h0};
        vecs[3]  = '{0, 2'b00, 0, 32'h0000_0000, 32'h0,         0, 32'h0000_00BB, 3, 0, 6'd0,  32'h0};
        vecs[4]  = '{0, 2'b00, 1, 32'h0000_0001, 32'h0,         0, 32'hFFFF_FFAA, 3, 0, 6'd0,  32'h0};
        vecs[5]  = '{0, 2'b01, 1, 32'h0000_0000, 32'h0,         0, 32'hFFFF_AABB, 3, 0, 6'd0,  32'h0};
        vecs[6]  = '{0, 2'b10, 0, 32'h0000_0000, 32'h0,         0, 32'h8899_AABB, 3, 0, 6'd0,  32'h0};
        vecs[7]  = '{1, 2'b10, 0, 32'h0000_0008, 32'hDEAD_BEEF, 0, 32'h0,         2, 1, 6'd2,  32'hDEAD_BEEF};
        vecs[8]  = '{0, 2'b10, 0, 32'h0000_0008, 32'h0,         0, 32'hDEAD_BEEF, 3, 0, 6'd0,  32'h0};
        vecs[9]  = '{1, 2'b00, 0, 32'h0000_0009, 32'hABCD_EF12, 0, 32'h0,         4, 1, 6'd2,  32'hDEAD_12EF};
        vecs[10] = '{1, 2'b01, 0, 32'h0000_000A, 32'h9999_5678, 0, 32'h0,         4, 1, 6'd2,  32'h5678_12EF};
        vecs[11] = '{1, 2'b00, 0, 32'h0000_000B, 32'h0000_0077, 0, 32'h0,         4, 1, 6'd2,  32'h7778_12EF};
        vecs[12] = '{0, 2'b10, 0, 32'h0000_0008, 32'h0,         0, 32'h7778_12EF, 3, 0, 6'd0,  32'h0};
        vecs[13] = '{0, 2'b10, 0, 32'h0000_0100, 32'h0,         1, 32'h0,         1, 0, 6'd0,  32'h0};
        vecs[14] = '{1, 2'b10, 0, 32'h0000_0100, 32'h0000_0001, 1, 32'h0,         1, 1, 6'd0,  32'h8899_AABB};
        vecs[15] = '{0, 2'b11, 0, 32'h0000_0004, 32'h0,         1, 32'h0,         1, 0, 6'd0,  32'h0};
        vecs[16] = '{0, 2'b10, 0, 32'h0000_0006, 32'h0,         1, 32'h0,         1, 0, 6'd0,  32'h0};
        vecs[17] = '{1, 2'b01, 0, 32'h0000_0003, 32'h0000_FFFF, 1, 32'h0,         1, 1, 6'd2,  32'h7778_12EF};
        vecs[18] = '{1, 2'b10, 0, 32'h0000_00FC, 32'hCAFE_F00D, 0, 32'h0,         2, 1, 6'd63, 32'hCAFE_F00D};
        vecs[19] = '{0, 2'b00, 1, 32'h0000_00FF, 32'h0,         0, 32'hFFFF_FFCA, 3, 0, 6'd0,  32'h0};
        vecs[20] = '{0, 2'b01, 0, 32'h0000_00FE, 32'h0,         0, 32'h0000_CAFE, 3, 0, 6'd0,  32'h0};
        vecs[21] = '{0, 2'b00, 0, 32'h0000_00FC, 32'h0,         0, 32'h0000_000D, 3, 0, 6'd0,  32'h0};
        vecs[22] = '{0, 2'b10, 0, 32'h0000_00FF, 32'h0,         1, 32'h0,         1, 0, 6'd0,  32'h0};
        vecs[23] = '{1, 2'b11, 0, 32'h0000_0008, 32'h1234_5678, 1, 32'h0,         1, 1, 6'd2,  32'h7778_12EF};

        #3;
        checkOutput("reset_req_ready", {31'h0, req_ready}, 32'h0);
        checkOutput("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset_mem_write", {31'h0, mem_write}, 32'h0);
        checkOutput("reset_mem_out", {31'h0, mem_out}, 32'h0);
        checkOutput("reset_mem_address", mem_address, 32'h0);

        @(posedge clk);
        #1;
        preloadWord(6'd0, 32'h8899_AABB);
        preloadWord(6'd2, 32'h1122_3344);
        preloadWord(6'd63, 32'h0000_0000);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Reset during the READ phase of a byte store to word 0x8
        rv0 = rv_cnt;
        mw0 = mw_cnt;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0000_0009;
        req_wdata  = 32'h0000_0055;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_mid_read_phase", {31'h0, mem_out}, 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_mem_out", {31'h0, mem_out}, 32'h0);
        checkOutput("rst_mid_mem_write", {31'h0, mem_write}, 32'h0);
        checkOutput("rst_mid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("rst_mid_req_ready", {31'h0, req_ready}, 32'h0);
        checkOutput("rst_mid_mem_address", mem_address, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("rst_mid_no_rsp", 32'(rv_cnt - rv0), 32'h0);
        checkOutput("rst_mid_no_write", 32'(mw_cnt - mw0), 32'h0);
        checkOutput("rst_mid_word_kept", mem[2], 32'h7778_12EF);
        rv = '{0, 2'b10, 0, 32'h0000_0008, 32'h0, 0, 32'h7778_12EF, 3, 0, 6'd0, 32'h0};
        applyStimulus(rv, 100);
        rv = '{0, 2'b00, 0, 32'h0000_0009, 32'h0, 0, 32'h0000_0012, 3, 0, 6'd0, 32'h0};
        applyStimulus(rv, 101);

        checkOutput("no_strobe_overlap", 32'(overlap_cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
